// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer.
package led_seq_pkg;

  // Display pattern selected by the mode button
  typedef enum logic [1:0] {
    ModeCount   = 2'd0,
    ModeScan    = 2'd1,
    ModeFill    = 2'd2,
    ModeBreathe = 2'd3
  } mode_e;

  // Highest fill level (all four red LEDs lit)
  localparam logic [3:0] FILL_MAX  = 4'd4;
  // Scan position where the direction turns back down
  localparam logic [3:0] SCAN_LAST = 4'd3;

  // Mode order wraps BREATHE -> COUNT
  function automatic mode_e next_mode(input mode_e mode);
    unique case (mode)
      ModeCount:   return ModeScan;
      ModeScan:    return ModeFill;
      ModeFill:    return ModeBreathe;
      ModeBreathe: return ModeCount;
      default:     return ModeCount;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Mode-button conditioning: 2-flop synchroniser, debounce counter and a one-cycle
// pulse on each rising edge of the debounced level.
module button_debounce #(
  parameter int unsigned DEBOUNCE_BITS = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [DEBOUNCE_BITS-1:0] CntOne = 1;

  logic                     sync1_q, sync2_q;
  logic                     stable_q, stable_d;
  logic                     stable_dly_q;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised input disagrees with the stable level
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == '1) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CntOne;
    end
  end

  // Synchroniser, debounce state and edge-detect delay
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  // Press only; a release (falling stable edge) is ignored
  assign press_o = stable_q & ~stable_dly_q;

endmodule

// File: rtl/led_sequencer.sv
// LED display sequencer: steps one of four red-LED patterns on TICK_IN and
// cycles patterns on a debounced button press. GLED5 acknowledges a mode change.
// Optional build macro LED_DIM_EN dims the COUNT/SCAN/FILL patterns to DIM_DUTY.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_BITS = 16,
  parameter int unsigned PWM_BITS      = 4,
  parameter int unsigned DIM_DUTY      = 4
) (
  input  logic CLK_IN,
  input  logic RST_N,
  input  logic TICK_IN,
  input  logic BTN_IN,
  output logic RLED1,
  output logic RLED2,
  output logic RLED3,
  output logic RLED4,
  output logic GLED5
);

`ifdef LED_DIM_EN
  localparam bit DimEn = 1'b1;
`else
  localparam bit DimEn = 1'b0;
`endif

  localparam logic [PWM_BITS-1:0] PwmOne    = 1;
  localparam logic [PWM_BITS-1:0] DutyMax   = '1;
  // One extra bit so a dim duty of 2^PWM_BITS (always on) is representable
  localparam logic [PWM_BITS:0]   DimDutyW  = (PWM_BITS + 1)'(DIM_DUTY);

  logic                press;
  mode_e               mode_q, mode_d;
  logic [3:0]          step_q, step_d;   // count value, scan position or fill level
  logic                dir_up_q, dir_up_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [3:0]          led_q, led_d;     // [3] = RLED1
  logic                gled_q, gled_d;
  logic [3:0]          all_ones;

  button_debounce #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_debounce (
    .clk_i  (CLK_IN),
    .rst_ni (RST_N),
    .btn_i  (BTN_IN),
    .press_o(press)
  );

  // Pattern state: a press restarts the next mode and outranks a coincident tick
  always_comb begin
    mode_d   = mode_q;
    step_d   = step_q;
    dir_up_d = dir_up_q;
    duty_d   = duty_q;
    if (press) begin
      mode_d   = next_mode(mode_q);
      step_d   = '0;
      dir_up_d = 1'b1;
      duty_d   = '0;
    end else if (TICK_IN) begin
      unique case (mode_q)
        ModeCount: step_d = step_q + 4'd1;
        ModeScan: begin
          if (dir_up_q) begin
            if (step_q == SCAN_LAST) begin
              step_d   = step_q - 4'd1;
              dir_up_d = 1'b0;
            end else begin
              step_d = step_q + 4'd1;
            end
          end else if (step_q == 4'd0) begin
            step_d   = 4'd1;
            dir_up_d = 1'b1;
          end else begin
            step_d = step_q - 4'd1;
          end
        end
        ModeFill: step_d = (step_q == FILL_MAX) ? 4'd0 : step_q + 4'd1;
        ModeBreathe: begin
          if (dir_up_q) begin
            if (duty_q == DutyMax) begin
              duty_d   = duty_q - PwmOne;
              dir_up_d = 1'b0;
            end else begin
              duty_d = duty_q + PwmOne;
            end
          end else if (duty_q == '0) begin
            duty_d   = PwmOne;
            dir_up_d = 1'b1;
          end else begin
            duty_d = duty_q - PwmOne;
          end
        end
        default: ;
      endcase
    end
  end

  // LED pattern decode from current state, PWM counter and acknowledge LED
  always_comb begin
    all_ones = 4'b1111;
    pwm_d    = pwm_q + PwmOne;
    unique case (mode_q)
      ModeCount:   led_d = step_q;
      ModeScan:    led_d = 4'b1000 >> step_q;
      ModeFill:    led_d = ~(all_ones >> step_q);
      ModeBreathe: led_d = {4{pwm_q < duty_q}};
      default:     led_d = 4'b0000;
    endcase
    if (DimEn && (mode_q != ModeBreathe)) begin
      led_d = led_d & {4{{1'b0, pwm_q} < DimDutyW}};
    end
    gled_d = gled_q;
    if (press) begin
      gled_d = 1'b0;
    end else if (TICK_IN) begin
      gled_d = 1'b1;
    end
  end

  // All state and registered outputs
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      mode_q   <= ModeCount;
      step_q   <= '0;
      dir_up_q <= 1'b1;
      duty_q   <= '0;
      pwm_q    <= '0;
      led_q    <= '0;
      gled_q   <= 1'b1;
    end else begin
      mode_q   <= mode_d;
      step_q   <= step_d;
      dir_up_q <= dir_up_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
      led_q    <= led_d;
      gled_q   <= gled_d;
    end
  end

  assign RLED1 = led_q[3];
  assign RLED2 = led_q[2];
  assign RLED3 = led_q[1];
  assign RLED4 = led_q[0];
  assign GLED5 = gled_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with a short debounce window (2^4 clocks).
module tb_led_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic tick;
  logic btn;
  logic rled1, rled2, rled3, rled4, gled5;
  logic [3:0] leds;

  int checks    = 0;
  int failures  = 0;
  int press_cnt = 0;
  int on_cnt;
  int off_cnt;

  always #5 clk = ~clk;

  assign leds = {rled1, rled2, rled3, rled4};

  led_sequencer #(
    .DEBOUNCE_BITS(4),
    .PWM_BITS     (4),
    .DIM_DUTY     (4)
  ) dut (
    .CLK_IN (clk),
    .RST_N  (rst_n),
    .TICK_IN(tick),
    .BTN_IN (btn),
    .RLED1  (rled1),
    .RLED2  (rled2),
    .RLED3  (rled3),
    .RLED4  (rled4),
    .GLED5  (gled5)
  );

  // Count debounced press pulses seen by the sequencer
  always @(posedge clk) begin
    if (dut.press === 1'b1) press_cnt++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the LEDs show the new state
  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_button();
    btn = 1'b1;
    repeat (30) @(negedge clk);
    btn = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    btn   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_leds", {4'd0, leds}, 8'h00);
    check("reset_gled", {7'd0, gled5}, 8'h01);
    check("reset_mode", {6'd0, 2'(dut.mode_q)}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // COUNT: 20 ticks
    for (int i = 1; i <= 20; i++) begin
      do_tick();
      if (i == 1)  check("count_t1",  {4'd0, leds}, 8'h01);
      if (i == 15) check("count_t15", {4'd0, leds}, 8'h0f);
      if (i == 16) check("count_t16", {4'd0, leds}, 8'h00);
      if (i == 20) check("count_t20", {4'd0, leds}, 8'h04);
    end

    // Clean press -> SCAN at position 0
    press_button();
    check("press_once", 8'(press_cnt), 8'd1);
    check("scan_mode",  {6'd0, 2'(dut.mode_q)}, 8'h01);
    check("gled_ack",   {7'd0, gled5}, 8'h00);
    check("scan_pos0",  {4'd0, leds}, 8'h08);

    // 10-clock glitch is rejected
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (30) @(negedge clk);
    check("glitch_press", 8'(press_cnt), 8'd1);
    check("glitch_mode",  {6'd0, 2'(dut.mode_q)}, 8'h01);

    // SCAN: lit index 2,3,4,3,2,1,2,3
    do_tick(); check("scan_t1", {4'd0, leds}, 8'h04);
    check("gled_back", {7'd0, gled5}, 8'h01);
    do_tick(); check("scan_t2", {4'd0, leds}, 8'h02);
    do_tick(); check("scan_t3", {4'd0, leds}, 8'h01);
    do_tick(); check("scan_t4", {4'd0, leds}, 8'h02);
    do_tick(); check("scan_t5", {4'd0, leds}, 8'h04);
    do_tick(); check("scan_t6", {4'd0, leds}, 8'h08);
    do_tick(); check("scan_t7", {4'd0, leds}, 8'h04);
    do_tick(); check("scan_t8", {4'd0, leds}, 8'h02);

    // FILL: lit counts 1,2,3,4,0,1
    press_button();
    check("fill_mode", {6'd0, 2'(dut.mode_q)}, 8'h02);
    check("fill_l0",   {4'd0, leds}, 8'h00);
    do_tick(); check("fill_t1", {4'd0, leds}, 8'h08);
    do_tick(); check("fill_t2", {4'd0, leds}, 8'h0c);
    do_tick(); check("fill_t3", {4'd0, leds}, 8'h0e);
    do_tick(); check("fill_t4", {4'd0, leds}, 8'h0f);
    do_tick(); check("fill_t5", {4'd0, leds}, 8'h00);
    do_tick(); check("fill_t6", {4'd0, leds}, 8'h08);

    // BREATHE: duty 0 never on, duty 8 on 8 of 16 clocks
    press_button();
    check("breathe_mode", {6'd0, 2'(dut.mode_q)}, 8'h03);
    on_cnt  = 0;
    off_cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (leds === 4'b1111) on_cnt++;
      if (leds === 4'b0000) off_cnt++;
    end
    check("duty0_on",  8'(on_cnt),  8'd0);
    check("duty0_off", 8'(off_cnt), 8'd16);
    repeat (8) do_tick();
    on_cnt  = 0;
    off_cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (leds === 4'b1111) on_cnt++;
      if (leds === 4'b0000) off_cnt++;
    end
    check("duty8_on",  8'(on_cnt),  8'd8);
    check("duty8_off", 8'(off_cnt), 8'd8);

    // Back to COUNT, step to 5, then press and tick in the same cycle
    press_button();
    check("count_again", {6'd0, 2'(dut.mode_q)}, 8'h00);
    repeat (5) do_tick();
    check("count_5", {4'd0, leds}, 8'h05);
    btn = 1'b1;
    repeat (18) @(negedge clk);
    check("press_due", {7'd0, dut.press}, 8'h01);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    check("coinc_mode", {6'd0, 2'(dut.mode_q)}, 8'h01);
    check("coinc_pos0", {4'd0, leds}, 8'h08);
    check("coinc_gled", {7'd0, gled5}, 8'h00);
    repeat (12) @(negedge clk);
    btn = 1'b0;
    repeat (30) @(negedge clk);

    // FILL, two ticks, then asynchronous reset mid-pattern
    press_button();
    do_tick();
    do_tick();
    check("fill_pre_rst", {4'd0, leds}, 8'h0c);
    #2 rst_n = 1'b0;
    #1;
    check("rst_leds", {4'd0, leds}, 8'h00);
    check("rst_gled", {7'd0, gled5}, 8'h01);
    check("rst_mode", {6'd0, 2'(dut.mode_q)}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_tick();
    check("post_rst_count", {4'd0, leds}, 8'h01);
    check("press_total", 8'(press_cnt), 8'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
